// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the seven-square VGA pattern sequencer.
package vga_sched_pkg;

    localparam int NUM_OBJECTS = 7;

    localparam logic [NUM_OBJECTS-1:0] MASK_FULL   = 7'h7F;
    localparam logic [NUM_OBJECTS-1:0] MASK_LAST   = 7'h40;
    localparam logic [NUM_OBJECTS-1:0] MASK_FIRST  = 7'h01;
    localparam logic [NUM_OBJECTS-1:0] MASK_DRAIN0 = 7'h7E;
    localparam logic [2:0]             ROT_LAST    = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ROTATE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Colour slot seen by square 'obj' under rotation 'rot': (obj + rot) mod 7.
    function automatic logic [2:0] obj_colour_idx(input logic [2:0] obj, input logic [2:0] rot);
        logic [3:0] s;
        s = {1'b0, obj} + {1'b0, rot};
        if (s >= 4'd7)
            s = s - 4'd7;
        return s[2:0];
    endfunction

endpackage

// File: rtl/vga_object_scheduler_sync2.sv
// Generic two-flop synchronizer for slow asynchronous inputs (switches).
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture; first stage may go metastable, second is clean.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vga_object_scheduler.sv
// Frame-synchronous fill / rotate / drain sequencer for the seven-square
// VGA test pattern. Everything updates on the V_SYNC falling edge, which
// lies in vertical blanking, so a displayed frame never tears.
//
// state  | meaning
// IDLE   | all squares hidden, waits for run on a step
// FILL   | squares appear one per step, 1 -> 7
// ROTATE | all visible, colour rotation 1..6 one per step
// DRAIN  | squares disappear one per step from square 1 upward
module vga_object_scheduler
    import vga_sched_pkg::*;
#(
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       CLOCK_50_I,
    input  logic                       resetn,
    input  logic                       vsync_i,
    input  logic                       run_i,
    input  logic                       pause_i,
    input  logic [5:0]                 period_i,
    output logic [NUM_OBJECTS-1:0]     object_mask_o,
    output logic [2:0]                 colour_rot_o,
    output logic [1:0]                 phase_o,
    output logic                       frame_tick_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count_o
);

    logic                       w_run_s;
    logic                       w_pause_s;
    logic                       w_tick;
    logic                       w_step;
    logic [5:0]                 w_period_m1;

    logic                       r_vsync_q;
    logic [5:0]                 r_div_cnt;
    logic                       r_frame_tick;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
    state_t                     r_state;
    logic [NUM_OBJECTS-1:0]     r_mask;
    logic [2:0]                 r_rot;

    sync2 #(.WIDTH(1)) u_sync_run (
        .i_clk   (CLOCK_50_I),
        .i_rst_n (resetn),
        .i_d     (run_i),
        .o_q     (w_run_s)
    );

    sync2 #(.WIDTH(1)) u_sync_pause (
        .i_clk   (CLOCK_50_I),
        .i_rst_n (resetn),
        .i_d     (pause_i),
        .o_q     (w_pause_s)
    );

    // vsync_q resets low so a low vsync_i after reset cannot fake a falling edge.
    assign w_tick      = r_vsync_q & ~vsync_i;
    assign w_period_m1 = (period_i == 6'd0) ? 6'd0 : (period_i - 6'd1);
    // '>=' lets a period shortened mid-count step immediately rather than wrap.
    assign w_step      = w_tick & ~w_pause_s & (r_div_cnt >= w_period_m1);

    // Frame edge detect, tick pulse, frame counter and frame divider.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_vsync_q    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
            r_div_cnt    <= '0;
        end else begin
            r_vsync_q    <= vsync_i;
            r_frame_tick <= w_tick;
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (!w_pause_s) begin
                    if (r_div_cnt >= w_period_m1)
                        r_div_cnt <= 6'd0;
                    else
                        r_div_cnt <= r_div_cnt + 6'd1;
                end
            end
        end
    end

    // Pattern state machine; advances only on divided steps.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_rot   <= '0;
        end else if (w_step) begin
            case (r_state)
                IDLE: begin
                    if (w_run_s) begin
                        r_state <= FILL;
                        r_mask  <= MASK_FIRST;
                    end
                end
                FILL: begin
                    if (r_mask == MASK_FULL) begin
                        r_state <= ROTATE;
                        r_rot   <= 3'd1;
                    end else begin
                        r_mask <= {r_mask[NUM_OBJECTS-2:0], 1'b1};
                    end
                end
                ROTATE: begin
                    if (r_rot == ROT_LAST) begin
                        r_state <= DRAIN;
                        r_rot   <= 3'd0;
                        r_mask  <= MASK_DRAIN0;
                    end else begin
                        r_rot <= r_rot + 3'd1;
                    end
                end
                DRAIN: begin
                    if (r_mask == MASK_LAST) begin
                        r_state <= IDLE;
                        r_mask  <= '0;
                    end else begin
                        r_mask <= {r_mask[NUM_OBJECTS-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_mask  <= '0;
                    r_rot   <= '0;
                end
            endcase
        end
    end

    assign object_mask_o = r_mask;
    assign colour_rot_o  = r_rot;
    assign phase_o       = r_state;
    assign frame_tick_o  = r_frame_tick;
    assign frame_count_o = r_frame_cnt;

endmodule
